// File: rtl/rf_arb_pkg.sv
// Shared definitions for the register file write-port arbiter.
//
// Holds the default widths and depth, the LU write request record and the
// hardwired-zero register ID. The optional starvation guard is enabled by
// defining RF_ARB_STARVE_GUARD_EN; its default limit lives here as well.
package rf_arb_pkg;

  localparam int unsigned RF_DATA_W       = 16;
  localparam int unsigned RF_REG_W        = 4;
  localparam int unsigned RF_DEPTH        = 2;
  localparam int unsigned RF_STARVE_LIMIT = 8;

  // Register 0 reads as zero; writes to it are never issued.
  localparam int unsigned RF_ZERO_REG = 0;

  // One queued write: destination register and data.
  typedef struct packed {
    logic [RF_REG_W-1:0]  reg_id;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_req_t;

endpackage

// File: rtl/rf_arb_fifo.sv
// In-order synchronous FIFO for queued LU register writes.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset (drops all entries)
//   push_i    - enqueue data_i this cycle (ignored when full)
//   data_i    - entry to enqueue
//   pop_i     - dequeue the head this cycle (ignored when empty)
//   head_o    - current head entry (valid when empty_o is low)
//   count_o   - registered occupancy, 0..DEPTH
//   full_o    - occupancy equals DEPTH
//   empty_o   - occupancy is zero
//
// DEPTH must be a power of two so the read/write pointers wrap naturally.
module rf_arb_fifo
  import rf_arb_pkg::*;
#(
  parameter int unsigned DEPTH = RF_DEPTH,
  parameter type         T     = rf_wr_req_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  T                           data_i,
  input  logic                       pop_i,
  output T                           head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  T                mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push_en, pop_en;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register file write-port arbiter.
//
// Shares the single register file write port between the writeback stage
// (WB, highest priority, no back-pressure) and a long-latency unit (LU,
// valid/ready). LU writes are always queued in an in-order FIFO and drain in
// cycles where WB does not write. Outputs are registered and drive the
// register file write port directly.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   wb_valid_i/reg/data - WB write request (ignored while wb_stall_o is high)
//   lu_valid_i/reg/data - LU write request, transfers on lu_valid_i & lu_ready_o
//   lu_ready_o          - FIFO has room (from registered occupancy only)
//   wb_stall_o          - WB must hold this cycle (starvation guard only)
//   rf_we_o/reg/data    - register file write port, one-cycle write pulses
//   fifo_count_o        - LU FIFO occupancy
//
// Build option: define RF_ARB_STARVE_GUARD_EN to add the starvation guard,
// which forces one WB stall after STARVE_LIMIT cycles of a full FIFO losing
// to WB. Without it wb_stall_o is tied low.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned DATA_W       = RF_DATA_W,
  parameter int unsigned REG_W        = RF_REG_W,
`ifdef RF_ARB_STARVE_GUARD_EN
  parameter int unsigned STARVE_LIMIT = RF_STARVE_LIMIT,
`endif
  parameter int unsigned DEPTH        = RF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_valid_i,
  input  logic [REG_W-1:0]       wb_reg_i,
  input  logic [DATA_W-1:0]      wb_data_i,
  input  logic                   lu_valid_i,
  input  logic [REG_W-1:0]       lu_reg_i,
  input  logic [DATA_W-1:0]      lu_data_i,
  output logic                   lu_ready_o,
  output logic                   wb_stall_o,
  output logic                   rf_we_o,
  output logic [REG_W-1:0]       rf_reg_o,
  output logic [DATA_W-1:0]      rf_data_o,
  output logic [$clog2(DEPTH):0] fifo_count_o
);

  localparam logic [REG_W-1:0] ZeroReg = REG_W'(RF_ZERO_REG);

  typedef struct packed {
    logic [REG_W-1:0]  reg_id;
    logic [DATA_W-1:0] data;
  } req_t;

  req_t lu_req, fifo_head;
  logic fifo_full, fifo_empty;
  logic lu_push, wb_grant, lu_grant;

  logic              rf_we_q, rf_we_d;
  logic [REG_W-1:0]  rf_reg_q, rf_reg_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;

  // ---------------------------------------------------------------------------
  // Handshake and grant
  // ---------------------------------------------------------------------------
  // Ready looks only at registered occupancy, so a same-cycle pop never
  // opens a slot early.
  assign lu_ready_o = ~rst & ~fifo_full;

  // R0 writes complete the handshake but are dropped instead of queued.
  assign lu_push = lu_valid_i & lu_ready_o & (lu_reg_i != ZeroReg);
  assign lu_req  = '{reg_id: lu_reg_i, data: lu_data_i};

  // An R0 WB write yields the slot to the FIFO head.
  assign wb_grant = wb_valid_i & ~wb_stall_o & (wb_reg_i != ZeroReg);
  assign lu_grant = ~wb_grant & ~fifo_empty;

  rf_arb_fifo #(
    .DEPTH (DEPTH),
    .T     (req_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (lu_push),
    .data_i  (lu_req),
    .pop_i   (lu_grant),
    .head_o  (fifo_head),
    .count_o (fifo_count_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Starvation guard
  // ---------------------------------------------------------------------------
`ifdef RF_ARB_STARVE_GUARD_EN
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  logic [StarveW-1:0] starve_q, starve_d;
  logic               wb_stall_q, wb_stall_d;

  // Counts edges where a full FIFO loses to WB. The stall cycle itself pops
  // the head, which clears the count, so the stall lasts exactly one cycle.
  always_comb begin
    starve_d   = starve_q;
    wb_stall_d = 1'b0;
    if (lu_grant || !fifo_full) begin
      starve_d = '0;
    end else if (wb_grant) begin
      if (starve_q == StarveW'(STARVE_LIMIT - 1)) begin
        starve_d   = '0;
        wb_stall_d = 1'b1;
      end else begin
        starve_d = starve_q + StarveW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q   <= '0;
      wb_stall_q <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      wb_stall_q <= wb_stall_d;
    end
  end

  assign wb_stall_o = wb_stall_q;
`else
  assign wb_stall_o = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Write port registers
  // ---------------------------------------------------------------------------
  // ID and data hold their last value when no write is granted.
  always_comb begin
    rf_we_d   = wb_grant | lu_grant;
    rf_reg_d  = rf_reg_q;
    rf_data_d = rf_data_q;
    if (wb_grant) begin
      rf_reg_d  = wb_reg_i;
      rf_data_d = wb_data_i;
    end else if (lu_grant) begin
      rf_reg_d  = fifo_head.reg_id;
      rf_data_d = fifo_head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q   <= 1'b0;
      rf_reg_q  <= '0;
      rf_data_q <= '0;
    end else begin
      rf_we_q   <= rf_we_d;
      rf_reg_q  <= rf_reg_d;
      rf_data_q <= rf_data_d;
    end
  end

  assign rf_we_o   = rf_we_q;
  assign rf_reg_o  = rf_reg_q;
  assign rf_data_o = rf_data_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter (DATA_W=16, REG_W=4,
// DEPTH=2). Inputs change 1 time unit after each rising edge; outputs are
// checked at that same point, i.e. they show the state loaded at that edge.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [3:0]  wb_reg;
  logic [15:0] wb_data;
  logic        lu_valid;
  logic [3:0]  lu_reg;
  logic [15:0] lu_data;
  logic        lu_ready;
  logic        wb_stall;
  logic        rf_we;
  logic [3:0]  rf_reg;
  logic [15:0] rf_data;
  logic [1:0]  fifo_count;

  int n_tests = 0;
  int n_fail  = 0;
  int r0_writes = 0;
  int dropped_writes = 0;

  rf_write_arbiter u_dut (
    .clk          (clk),
    .rst          (rst),
    .wb_valid_i   (wb_valid),
    .wb_reg_i     (wb_reg),
    .wb_data_i    (wb_data),
    .lu_valid_i   (lu_valid),
    .lu_reg_i     (lu_reg),
    .lu_data_i    (lu_data),
    .lu_ready_o   (lu_ready),
    .wb_stall_o   (wb_stall),
    .rf_we_o      (rf_we),
    .rf_reg_o     (rf_reg),
    .rf_data_o    (rf_data),
    .fifo_count_o (fifo_count)
  );

  always #5 clk = ~clk;

  // Writes to R0, and writes of entries that a reset should have dropped.
  always @(negedge clk) begin
    if (rf_we && rf_reg == 4'd0) r0_writes++;
    if (rf_we && (rf_reg == 4'd11 || rf_reg == 4'd12)) dropped_writes++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_set(input logic v, input logic [3:0] r, input logic [15:0] d);
    wb_valid = v;
    wb_reg   = r;
    wb_data  = d;
  endtask

  task automatic lu_set(input logic v, input logic [3:0] r, input logic [15:0] d);
    lu_valid = v;
    lu_reg   = r;
    lu_data  = d;
  endtask

  task automatic check_wr(input string tag, input logic [3:0] r, input logic [15:0] d);
    check({tag, ".we"}, 32'(rf_we), 32'd1);
    check({tag, ".reg"}, 32'(rf_reg), 32'(r));
    check({tag, ".data"}, 32'(rf_data), 32'(d));
  endtask

  initial begin
    rst = 1'b1;
    wb_set(1'b0, 4'd0, 16'h0);
    lu_set(1'b0, 4'd0, 16'h0);

    // Reset state
    check("rst.lu_ready", 32'(lu_ready), 32'd0);
    tick();
    tick();
    check("rst.rf_we", 32'(rf_we), 32'd0);
    check("rst.rf_reg", 32'(rf_reg), 32'd0);
    check("rst.rf_data", 32'(rf_data), 32'd0);
    check("rst.wb_stall", 32'(wb_stall), 32'd0);
    check("rst.count", 32'(fifo_count), 32'd0);
    check("rst.lu_ready_in_rst", 32'(lu_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("rst.lu_ready_after", 32'(lu_ready), 32'd1);

    // Single WB write: latency 1, one-cycle pulse, ID/data held afterwards
    wb_set(1'b1, 4'd5, 16'hBEEF);
    tick();
    check_wr("wb1", 4'd5, 16'hBEEF);
    wb_set(1'b0, 4'd0, 16'h0);
    tick();
    check("wb1.we_off", 32'(rf_we), 32'd0);
    check("wb1.reg_hold", 32'(rf_reg), 32'd5);
    check("wb1.data_hold", 32'(rf_data), 32'hBEEF);

    // Single LU write: always through the FIFO, latency 2
    lu_set(1'b1, 4'd3, 16'h1234);
    tick();
    check("lu1.count1", 32'(fifo_count), 32'd1);
    check("lu1.we_early", 32'(rf_we), 32'd0);
    lu_set(1'b0, 4'd0, 16'h0);
    tick();
    check_wr("lu1", 4'd3, 16'h1234);
    check("lu1.count0", 32'(fifo_count), 32'd0);
    tick();
    check("lu1.we_off", 32'(rf_we), 32'd0);

    // WB busy every cycle, three LU pushes: FIFO fills after two
    wb_set(1'b1, 4'd1, 16'h0101);
    lu_set(1'b1, 4'd8, 16'h00A1);
    tick();
    check_wr("bp.wb1", 4'd1, 16'h0101);
    check("bp.count1", 32'(fifo_count), 32'd1);
    wb_set(1'b1, 4'd2, 16'h0202);
    lu_set(1'b1, 4'd9, 16'h00A2);
    tick();
    check_wr("bp.wb2", 4'd2, 16'h0202);
    check("bp.count2", 32'(fifo_count), 32'd2);
    lu_set(1'b1, 4'd10, 16'h00A3);
    check("bp.ready_full", 32'(lu_ready), 32'd0);
    wb_set(1'b1, 4'd3, 16'h0303);
    tick();
    check_wr("bp.wb3", 4'd3, 16'h0303);
    check("bp.count_hold", 32'(fifo_count), 32'd2);
    check("bp.ready_full2", 32'(lu_ready), 32'd0);
    wb_set(1'b1, 4'd4, 16'h0404);
    tick();
    check_wr("bp.wb4", 4'd4, 16'h0404);
    wb_set(1'b0, 4'd0, 16'h0);
    tick();
    check_wr("bp.lu1", 4'd8, 16'h00A1);
    check("bp.count_after_pop", 32'(fifo_count), 32'd1);
    check("bp.ready_again", 32'(lu_ready), 32'd1);
    tick();  // third entry accepted while second drains
    check_wr("bp.lu2", 4'd9, 16'h00A2);
    check("bp.count_pushpop", 32'(fifo_count), 32'd1);
    lu_set(1'b0, 4'd0, 16'h0);
    tick();
    check_wr("bp.lu3", 4'd10, 16'h00A3);
    check("bp.count_empty", 32'(fifo_count), 32'd0);
    tick();
    check("bp.we_off", 32'(rf_we), 32'd0);

    // WB to R0 yields the slot to a queued LU write
    wb_set(1'b1, 4'd2, 16'h2222);
    lu_set(1'b1, 4'd7, 16'h0077);
    tick();
    check_wr("r0.wb", 4'd2, 16'h2222);
    lu_set(1'b0, 4'd0, 16'h0);
    wb_set(1'b1, 4'd0, 16'hFFFF);
    tick();
    check_wr("r0.lu", 4'd7, 16'h0077);
    wb_set(1'b0, 4'd0, 16'h0);
    // LU to R0: handshake completes, nothing is queued
    lu_set(1'b1, 4'd0, 16'h5555);
    check("r0.lu_ready", 32'(lu_ready), 32'd1);
    tick();
    check("r0.lu_count", 32'(fifo_count), 32'd0);
    check("r0.we_lu_r0", 32'(rf_we), 32'd0);
    lu_set(1'b0, 4'd0, 16'h0);
    tick();
    check("r0.we_off", 32'(rf_we), 32'd0);
    check("r0.reg_hold", 32'(rf_reg), 32'd7);

    // Reset with two queued entries drops them
    wb_set(1'b1, 4'd1, 16'h1111);
    lu_set(1'b1, 4'd11, 16'h0B0B);
    tick();
    lu_set(1'b1, 4'd12, 16'h0C0C);
    tick();
    check("mrst.count_full", 32'(fifo_count), 32'd2);
    wb_set(1'b0, 4'd0, 16'h0);
    lu_set(1'b0, 4'd0, 16'h0);
    rst = 1'b1;
    #1;
    check("mrst.ready_in_rst", 32'(lu_ready), 32'd0);
    tick();
    check("mrst.count", 32'(fifo_count), 32'd0);
    check("mrst.we", 32'(rf_we), 32'd0);
    rst = 1'b0;
    tick();
    check("mrst.we_after1", 32'(rf_we), 32'd0);
    tick();
    check("mrst.we_after2", 32'(rf_we), 32'd0);
    check("mrst.count_after", 32'(fifo_count), 32'd0);

    // Full FIFO with WB continuous: stall only in the guard build
    wb_set(1'b1, 4'd6, 16'h6666);
    lu_set(1'b1, 4'd13, 16'h0D0D);
    tick();
    lu_set(1'b1, 4'd14, 16'h0E0E);
    tick();
    lu_set(1'b0, 4'd0, 16'h0);
    check("starve.count_full", 32'(fifo_count), 32'd2);
`ifdef RF_ARB_STARVE_GUARD_EN
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("starve.no_stall%0d", i), 32'(wb_stall), 32'd0);
      check($sformatf("starve.wb_reg%0d", i), 32'(rf_reg), 32'd6);
    end
    tick();
    check("starve.stall", 32'(wb_stall), 32'd1);
    tick();
    check_wr("starve.head", 4'd13, 16'h0D0D);
    check("starve.stall_off", 32'(wb_stall), 32'd0);
    check("starve.count1", 32'(fifo_count), 32'd1);
    tick();
    check_wr("starve.wb_resume", 4'd6, 16'h6666);
`else
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("nostarve.stall%0d", i), 32'(wb_stall), 32'd0);
      check($sformatf("nostarve.wb_reg%0d", i), 32'(rf_reg), 32'd6);
    end
    check("nostarve.count", 32'(fifo_count), 32'd2);
    wb_set(1'b0, 4'd0, 16'h0);
    tick();
    check_wr("nostarve.lu1", 4'd13, 16'h0D0D);
`endif
    wb_set(1'b0, 4'd0, 16'h0);
    tick();
    check_wr("starve.drain", 4'd14, 16'h0E0E);
    tick();
    check("starve.count0", 32'(fifo_count), 32'd0);
    check("starve.we_off", 32'(rf_we), 32'd0);

    tick();
    check("mon.r0_writes", 32'(r0_writes), 32'd0);
    check("mon.dropped_writes", 32'(dropped_writes), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
